// File: rtl/fa_chk_pkg.sv
// Shared types, sizes and the reference full-adder function for the
// full-adder exhaustive checker.
package fa_chk_pkg;

  localparam int NUM_COMBOS = 8;
  localparam int ERR_W      = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } fa_chk_state_t;

  // Expected {cout, sum} for operand vector idx = {A, B, Cin}.
  function automatic logic [1:0] fa_expected(input logic [2:0] idx);
    logic a;
    logic b;
    logic c;
    a = idx[2];
    b = idx[1];
    c = idx[0];
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/fa_golden_model.sv
// Combinational reference full adder. Kept in its own module so it shares
// no implementation with the adder under test.
module fa_golden_model
  import fa_chk_pkg::*;
(
  input  logic [2:0] idx,
  output logic       exp_sum,
  output logic       exp_cout
);

  logic [1:0] expected;

  assign expected = fa_expected(idx);
  assign exp_sum  = expected[0];
  assign exp_cout = expected[1];

endmodule

// File: rtl/fa_exhaustive_checker.sv
// On-chip exhaustive self-test for a 1-bit full adder: drives all eight
// {A,B,Cin} vectors N_PASSES times, waits SETTLE_CYCLES per vector, compares
// the adder outputs with a golden model and reports pass / error count /
// per-vector fail map.
// Build option: define FA_CHK_HALT_ON_ERR_EN to stop at the first mismatch,
// leaving the operands frozen on the failing vector.
module fa_exhaustive_checker
  import fa_chk_pkg::*;
#(
  parameter int N_PASSES      = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  a_o,
  output logic                  b_o,
  output logic                  cin_o,
  input  logic                  sum_i,
  input  logic                  cout_i,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic [NUM_COMBOS-1:0] fail_vec
);

`ifdef FA_CHK_HALT_ON_ERR_EN
  localparam bit HALT_ON_ERR = 1'b1;
`else
  localparam bit HALT_ON_ERR = 1'b0;
`endif

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [3:0]       LAST_PASS   = 4'(N_PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  fa_chk_state_t         state_reg;
  logic [2:0]            idx_reg;
  logic [3:0]            pass_cnt_reg;
  logic [3:0]            settle_cnt_reg;

  logic                  exp_sum;
  logic                  exp_cout;
  logic                  mismatch;
  logic [ERR_W-1:0]      err_count_next;
  logic [NUM_COMBOS-1:0] fail_vec_next;

  fa_golden_model u_golden (
    .idx      (idx_reg),
    .exp_sum  (exp_sum),
    .exp_cout (exp_cout)
  );

  // A vector with both outputs wrong is still a single error.
  assign mismatch = (sum_i != exp_sum) || (cout_i != exp_cout);

  // Error count saturates rather than wrapping.
  assign err_count_next = !mismatch              ? err_count :
                          (err_count == ERR_MAX) ? err_count :
                                                   err_count + 1'b1;

  // Sticky per-vector fail map: only the bit of the vector under check can set.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_COMBOS; gi++) begin : g_fail_bit
      assign fail_vec_next[gi] = fail_vec[gi] | (mismatch && (idx_reg == 3'(gi)));
    end
  endgenerate

  // Sweep sequencer with all status outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      pass_cnt_reg   <= '0;
      settle_cnt_reg <= '0;
      a_o            <= 1'b0;
      b_o            <= 1'b0;
      cin_o          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_vec       <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            err_count    <= '0;
            fail_vec     <= '0;
            idx_reg      <= '0;
            pass_cnt_reg <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            state_reg    <= DRIVE;
          end
        end

        DRIVE: begin
          a_o            <= idx_reg[2];
          b_o            <= idx_reg[1];
          cin_o          <= idx_reg[0];
          settle_cnt_reg <= SETTLE_LOAD;
          state_reg      <= SETTLE;
        end

        SETTLE: begin
          settle_cnt_reg <= settle_cnt_reg - 1'b1;
          if (settle_cnt_reg <= 4'd1) begin
            state_reg <= CHECK;
          end
        end

        CHECK: begin
          err_count <= err_count_next;
          fail_vec  <= fail_vec_next;
          if (HALT_ON_ERR && mismatch) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= 1'b0;
            state_reg <= DONE;
          end else if (idx_reg != 3'd7) begin
            idx_reg   <= idx_reg + 1'b1;
            state_reg <= DRIVE;
          end else if (pass_cnt_reg != LAST_PASS) begin
            idx_reg      <= '0;
            pass_cnt_reg <= pass_cnt_reg + 1'b1;
            state_reg    <= DRIVE;
          end else begin
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= (err_count_next == '0);
            state_reg <= DONE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fa_exhaustive_checker.sv
// Self-checking bench for fa_exhaustive_checker. Two checker instances
// (default and multi-pass) each drive a behavioural full adder with
// injectable per-vector output faults; a run-level reference model predicts
// the outcome and a monitor compares it when done rises.
module tb_fa_exhaustive_checker;

  localparam int P0 = 1;
  localparam int S0 = 2;
  localparam int P1 = 2;
  localparam int S1 = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] start;
  logic [1:0] a_o, b_o, cin_o, sum_i, cout_i, busy, done, pass;
  logic [7:0] err_count [2];
  logic [7:0] fail_vec  [2];
  logic [7:0] flip_sum  [2];
  logic [7:0] flip_cout [2];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int accept_cyc [2];

  typedef struct {
    int err;
    int fv;
    int pass;
    int lat;
    int ops;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  fa_exhaustive_checker #(.N_PASSES(P0), .SETTLE_CYCLES(S0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
    .a_o(a_o[0]), .b_o(b_o[0]), .cin_o(cin_o[0]),
    .sum_i(sum_i[0]), .cout_i(cout_i[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(err_count[0]), .fail_vec(fail_vec[0])
  );

  fa_exhaustive_checker #(.N_PASSES(P1), .SETTLE_CYCLES(S1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
    .a_o(a_o[1]), .b_o(b_o[1]), .cin_o(cin_o[1]),
    .sum_i(sum_i[1]), .cout_i(cout_i[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(err_count[1]), .fail_vec(fail_vec[1])
  );

  // Adder under test: arithmetic sum of the three bits, with optional faults.
  always_comb begin
    sum_i  = '0;
    cout_i = '0;
    for (int i = 0; i < 2; i++) begin
      sum_i[i]  = (((int'(a_o[i]) + int'(b_o[i]) + int'(cin_o[i])) % 2) == 1)
                  ^ flip_sum[i][{a_o[i], b_o[i], cin_o[i]}];
      cout_i[i] = (((int'(a_o[i]) + int'(b_o[i]) + int'(cin_o[i])) / 2) == 1)
                  ^ flip_cout[i][{a_o[i], b_o[i], cin_o[i]}];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Outcome of one run predicted from which vectors are faulty.
  function automatic exp_t model(input int passes, input int settle,
                                 input logic [7:0] fs, input logic [7:0] fc);
    exp_t e;
    logic [7:0] bad;
    int tot;
    bad = fs | fc;
`ifdef FA_CHK_HALT_ON_ERR_EN
    for (int k = 0; k < 8; k++) begin
      if (bad[k]) begin
        e.err  = 1;
        e.fv   = 1 << k;
        e.pass = 0;
        e.lat  = (k + 1) * (settle + 2);
        e.ops  = k;
        return e;
      end
    end
`endif
    tot    = passes * $countones(bad);
    e.err  = (tot > 255) ? 255 : tot;
    e.fv   = int'(bad);
    e.pass = (bad == 8'h00) ? 1 : 0;
    e.lat  = passes * 8 * (settle + 2);
    e.ops  = 7;
    return e;
  endfunction

  task automatic monitor(input int i);
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && done[i] && !prev) begin
        if ((i == 0 ? q0.size() : q1.size()) == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL u%0d.unexpected_done: got done=1 expected no pending run", i);
        end else begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("u%0d.err_count", i), int'(err_count[i]), e.err);
          chk($sformatf("u%0d.fail_vec", i), int'(fail_vec[i]), e.fv);
          chk($sformatf("u%0d.pass", i), int'(pass[i]), e.pass);
          chk($sformatf("u%0d.latency", i), cyc - accept_cyc[i], e.lat);
          chk($sformatf("u%0d.operands", i), int'({a_o[i], b_o[i], cin_o[i]}), e.ops);
          chk($sformatf("u%0d.busy_at_done", i), int'(busy[i]), 0);
          $display("run u%0d: err=%0d fail_vec=%02h pass=%0d latency=%0d",
                   i, err_count[i], fail_vec[i], pass[i], cyc - accept_cyc[i]);
        end
      end
      prev = done[i];
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  // Pulse start, record the expectation and check the accept-edge clearing.
  task automatic kick(input int i, input logic [7:0] fs, input logic [7:0] fc, output exp_t e);
    flip_sum[i]  = fs;
    flip_cout[i] = fc;
    e = model((i == 0) ? P0 : P1, (i == 0) ? S0 : S1, fs, fc);
    @(negedge clk);
    start[i] = 1'b1;
    if (i == 0) q0.push_back(e); else q1.push_back(e);
    @(negedge clk);
    start[i] = 1'b0;
    accept_cyc[i] = cyc;
    chk($sformatf("u%0d.busy_after_start", i), int'(busy[i]), 1);
    chk($sformatf("u%0d.done_after_start", i), int'(done[i]), 0);
    chk($sformatf("u%0d.pass_after_start", i), int'(pass[i]), 0);
    chk($sformatf("u%0d.err_cleared", i), int'(err_count[i]), 0);
    chk($sformatf("u%0d.fv_cleared", i), int'(fail_vec[i]), 0);
  endtask

  task automatic run(input int i, input logic [7:0] fs, input logic [7:0] fc, input int ignore_at);
    exp_t e;
    int t;
    kick(i, fs, fc, e);
    t = 0;
    if (ignore_at > 0 && ignore_at < e.lat - 1) begin
      repeat (ignore_at) @(negedge clk);
      start[i] = 1'b1;
      @(negedge clk);
      start[i] = 1'b0;
      t = ignore_at + 1;
    end
    while (!done[i] && t < e.lat + 20) begin
      @(negedge clk);
      t++;
    end
    if (!done[i]) begin
      n_checks++;
      n_fail++;
      $display("FAIL u%0d.timeout: got done=0 after %0d cycles expected done", i, t);
    end
    @(negedge clk);
    chk($sformatf("u%0d.sb_drained", i), (i == 0) ? q0.size() : q1.size(), 0);
    if (i == 0) q0.delete(); else q1.delete();
  endtask

  task automatic check_reset_values(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.u%0d.operands", tag, i), int'({a_o[i], b_o[i], cin_o[i]}), 0);
      chk($sformatf("%s.u%0d.busy", tag, i), int'(busy[i]), 0);
      chk($sformatf("%s.u%0d.done", tag, i), int'(done[i]), 0);
      chk($sformatf("%s.u%0d.pass", tag, i), int'(pass[i]), 0);
      chk($sformatf("%s.u%0d.err_count", tag, i), int'(err_count[i]), 0);
      chk($sformatf("%s.u%0d.fail_vec", tag, i), int'(fail_vec[i]), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int inst;
    logic [7:0] fs;
    logic [7:0] fc;
    start        = '0;
    flip_sum[0]  = '0;
    flip_sum[1]  = '0;
    flip_cout[0] = '0;
    flip_cout[1] = '0;

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Good adder, with a start pulse ignored mid-run.
    run(0, 8'h00, 8'h00, 10);
    // Restart from DONE with Cout stuck at 0 (faults where Cout should be 1).
    run(0, 8'h00, 8'hE8, 0);
    // Sum inverted on every vector, two passes.
    run(1, 8'hFF, 8'h00, 7);
    // Both outputs wrong on one vector still counts once per pass.
    run(1, 8'h20, 8'h20, 0);

    // Asynchronous reset during SETTLE of vector 4 aborts the run.
    kick(0, 8'h00, 8'h00, e);
    repeat (4 * (S0 + 2) + 2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrun_reset");
    q0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(0, 8'h00, 8'h00, 0);

    // Sum stuck at 0 (faults where Sum should be 1).
    run(0, 8'h96, 8'h00, 0);

    for (int r = 0; r < 10; r++) begin
      inst = int'($urandom_range(0, 1));
      fs = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      fc = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      run(inst, fs, fc, int'($urandom_range(0, 25)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fa_exhaustive_checker.md
Name: fa_exhaustive_checker

Overview:
Hardware-side driver/checker for the 1-bit full adder. It generates the full adder's operands A, B and Cin, and consumes its Sum and Cout. On each start it sweeps all 8 {A,B,Cin} combinations, waits a settle window, and samples the DUT outputs. It compares them against an internal golden model, accumulates the result as a pass flag, an error count and a per-vector fail map, and reports completion. It sits beside the FA instance as an on-chip self-test, replacing stimulus that would otherwise exist only in simulation.

Parameters:
N_PASSES, 1, number of complete 8-vector sweeps per start (1..15)
SETTLE_CYCLES, 2, cycles between driving a vector and sampling the DUT (1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a run; accepted only in IDLE or DONE
a_o  out  1  operand A to DUT (registered)
b_o  out  1  operand B to DUT (registered)
cin_o  out  1  carry-in to DUT (registered)
sum_i  in  1  DUT Sum
cout_i  in  1  DUT Cout
busy  out  1  high from the cycle after start is accepted until DONE is entered
done  out  1  high in DONE; held until the next accepted start or reset
pass  out  1  valid while done=1; 1 iff err_count==0
err_count  out  8  mismatching samples this run, saturating at 255
fail_vec  out  8  bit i set if combination i mismatched in any pass; i={A,B,Cin}

Behaviour:
- Reset (async, rst_n=0): state=IDLE; a_o=b_o=cin_o=0; busy=done=pass=0; err_count=0; fail_vec=0; vector index=0; pass counter=0; settle counter=0. Asserting reset mid-run aborts immediately, with no partial results kept.
- Index idx[2:0] maps to {a_o,b_o,cin_o}=idx. Golden model: exp_sum=^idx; exp_cout=(A&B)|(A&Cin)|(B&Cin).
- FSM states and transitions:
  - IDLE: when start=1, clear err_count and fail_vec, set idx=0 and pass counter=0, go to DRIVE.
  - DRIVE (1 cycle): register the idx onto a_o/b_o/cin_o, load settle counter=SETTLE_CYCLES, go to SETTLE.
  - SETTLE: decrement the settle counter; when it reaches 1, go to CHECK. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
  - CHECK (1 cycle): sample sum_i/cout_i. On any mismatch, err_count+=1 (saturating) and fail_vec[idx]=1. Then:
    - idx<7: idx+=1, go to DRIVE.
    - idx==7 and this is not the last pass: idx=0, pass counter+=1, go to DRIVE.
    - otherwise: go to DONE.
  - DONE: done=1; pass=(err_count==0); operands hold the last vector (3'b111). start=1 behaves as in IDLE.
- Latency: each vector takes SETTLE_CYCLES+2 cycles. Total run = N_PASSES*8*(SETTLE_CYCLES+2) cycles from the start-accept edge to done rising. With defaults this is 32 cycles.
- start while busy is ignored, with no effect on counters.
- Both sum_i and cout_i wrong on one vector counts 1 error, not 2.
- err_count never wraps; it holds at 255.
- pass is driven 0 whenever done=0.

Optional Feature:
FA_CHK_HALT_ON_ERR_EN
- Defined: the first mismatch in CHECK goes straight to DONE. Operands stay frozen on the failing vector; err_count=1; fail_vec has exactly one bit set.
- Undefined: the full sweep always completes as described above.

Decomposition:
- Shared package fa_chk_pkg holds:
  - state enum (IDLE, DRIVE, SETTLE, CHECK, DONE)
  - NUM_COMBOS=8, ERR_W=8
  - golden-model expected-output function
- One natural sub-module: fa_golden_model, a combinational full adder (idx in, exp_sum/exp_cout out). It is kept separate so its implementation is independent of the DUT's.

Test Plan:
- Correct FA attached, defaults, start pulse -> done rises exactly 32 cycles after accept; pass=1, err_count=0, fail_vec=8'h00.
- Cout stuck-at-0 DUT -> err_count=4, fail_vec=8'hE8 (idx 3,5,6,7), pass=0.
- Sum inverted DUT, N_PASSES=2 -> err_count=16, fail_vec=8'hFF, done after 64 cycles.
- start pulsed at cycle 10 of a run, and again in DONE -> first pulse ignored; second restarts with err_count/fail_vec cleared on the accept edge and done dropping.
- rst_n low during SETTLE of idx=4 -> all outputs 0 asynchronously; a later start runs a full clean 32-cycle sweep.
- FA_CHK_HALT_ON_ERR_EN defined, Sum stuck-at-0 -> halts on idx=1 (first vector with exp_sum=1); {a_o,b_o,cin_o}=3'b001, err_count=1, fail_vec=8'h02.
